// File: rtl/aes_word_serializer4_if.sv
// Handshake bundle between the word source, the serializer and the MUX41X1 byte-lane mux.
// master = upstream/downstream environment, slave = serializer.
interface aes_word_serializer4_if #(
    parameter int BYTE_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*BYTE_W-1:0]   in_word;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            sel;
    logic [BYTE_W-1:0]     out_byte;
    logic                  out_last;
    logic                  out_par;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, sel, out_byte, out_last, out_par
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, sel, out_byte, out_last, out_par
    );
endinterface

// File: rtl/aes_word_serializer4.sv
// Word-to-byte serializer feeding the MUX41X1 4:1 lane mux; drives {S1,S0} and the selected byte.
// Optional odd-parity output per beat when SERIAL_PARITY_EN is defined (otherwise OUT_PAR is 1).
//
// state | meaning
// IDLE  | buffer empty, accepting a word, no beat on the output
// SHIFT | word buffered, presenting lane lane_q; next word accepted only on the lane-3 beat
module aes_word_serializer4 #(
    parameter int BYTE_W = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    aes_word_serializer4_if.slave        bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [1:0]          lane_q, lane_d;
    logic [1:0]          sel_q, sel_d;
    logic [4*BYTE_W-1:0] buf_q, buf_d;
    logic                load;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
            sel_q   <= 2'b00;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            sel_q   <= sel_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        buf_d         = buf_q;
        load          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                    lane_d  = 2'd0;
                end
            end
            SHIFT: begin
                bus.out_valid = 1'b1;
                // Word slot frees up only as the last lane leaves, so ready follows OUT_READY there.
                bus.in_ready  = bus.out_ready && (lane_q == 2'd3);
                if (bus.out_ready) begin
                    if (lane_q != 2'd3) begin
                        lane_d = lane_q + 2'd1;
                    end else if (bus.in_valid) begin
                        load   = 1'b1;
                        lane_d = 2'd0;
                    end else begin
                        state_d = IDLE;
                        lane_d  = 2'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            buf_d = bus.in_word;
        end
        // MUX41X1 decode: lane0..3 -> SEL 00,10,01,11, i.e. bits of lane swapped.
        sel_d = {lane_d[0], lane_d[1]};
    end

    always_comb begin
        bus.out_byte = buf_q[BYTE_W-1:0];
        case (lane_q)
            2'd0: bus.out_byte = buf_q[BYTE_W-1:0];
            2'd1: bus.out_byte = buf_q[2*BYTE_W-1:BYTE_W];
            2'd2: bus.out_byte = buf_q[3*BYTE_W-1:2*BYTE_W];
            2'd3: bus.out_byte = buf_q[4*BYTE_W-1:3*BYTE_W];
            default: bus.out_byte = buf_q[BYTE_W-1:0];
        endcase
    end

    assign bus.sel      = sel_q;
    assign bus.out_last = (lane_q == 2'd3) && bus.out_valid;

`ifdef SERIAL_PARITY_EN
    logic [3:0] par_q, par_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            par_q <= 4'hF;
        end else begin
            par_q <= par_d;
        end
    end

    always_comb begin
        par_d = par_q;
        if (load) begin
            for (int i = 0; i < 4; i++) begin
                par_d[i] = ~^bus.in_word[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign bus.out_par = par_q[lane_q];
`else
    assign bus.out_par = 1'b1;
`endif
endmodule

// File: tb/tb_aes_word_serializer4.sv
// Scoreboard bench for aes_word_serializer4: beats are queued on input transfer, checked on output transfer.
module tb_aes_word_serializer4;
    logic clk = 1'b0;
    logic rst = 1'b1;

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] sel;
        logic       last;
        logic       par;
    } beat_t;

    aes_word_serializer4_if #(.BYTE_W(8)) bus ();

    aes_word_serializer4 #(.BYTE_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    beat_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic exp_par(input logic [7:0] b);
`ifdef SERIAL_PARITY_EN
        return ~^b;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [1:0] exp_sel(input int lane);
        logic [1:0] m [4];
        m[0] = 2'b00; m[1] = 2'b10; m[2] = 2'b01; m[3] = 2'b11;
        return m[lane];
    endfunction

    // Monitor: pop before push so a same-cycle last-beat/new-word pair stays ordered.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", 32'(bus.out_byte), 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    chk("byte", 32'(bus.out_byte), 32'(e.b));
                    chk("sel",  32'(bus.sel),      32'(e.sel));
                    chk("last", 32'(bus.out_last), 32'(e.last));
                    chk("par",  32'(bus.out_par),  32'(e.par));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                logic [31:0] w;
                w = bus.in_word;
                for (int l = 0; l < 4; l++) begin
                    beat_t e;
                    e.b    = w[l*8 +: 8];
                    e.sel  = exp_sel(l);
                    e.last = (l == 3);
                    e.par  = exp_par(w[l*8 +: 8]);
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        bus.in_word  = w;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_word  = $urandom();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b1;

        // Reset held 3 cycles with random inputs.
        repeat (3) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_word   = $urandom();
            bus.out_ready = 1'($urandom_range(0, 1));
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid",    32'(bus.out_valid), 32'd0);
        chk("rst_sel",      32'(bus.sel),       32'd0);
        chk("rst_byte",     32'(bus.out_byte),  32'd0);
        chk("rst_last",     32'(bus.out_last),  32'd0);
        chk("rst_par",      32'(bus.out_par),   32'd1);
        chk("rst_in_ready", 32'(bus.in_ready),  32'd1);

        // Single word, 4 consecutive beats then idle.
        send_word(32'h44332211);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_valid", 32'(bus.out_valid), 32'd1);
            chk("single_last",  32'(bus.out_last),  32'(i == 3));
        end
        @(negedge clk);
        chk("single_idle", 32'(bus.out_valid), 32'd0);

        // Back-to-back words: 8 beats, no bubble, IN_READY only on lane-3 beats.
        send_word(32'hA3A2A1A0);
        fork
            send_word(32'hB3B2B1B0);
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    chk("b2b_valid",    32'(bus.out_valid), 32'd1);
                    chk("b2b_in_ready", 32'(bus.in_ready),  32'((i % 4) == 3));
                end
            end
        join
        @(negedge clk);
        chk("b2b_idle", 32'(bus.out_valid), 32'd0);

        // Backpressure on lane2 for 5 cycles.
        send_word(32'hC3C2C1C0);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_sel",   32'(bus.sel),       32'h1);
            chk("bp_byte",  32'(bus.out_byte),  32'hC2);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_resume_sel", 32'(bus.sel), 32'h3);
        repeat (3) @(negedge clk);

        // Mid-word reset after lane1.
        send_word(32'hDEADBEEF);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_sel",   32'(bus.sel),       32'd0);
        chk("mrst_byte",  32'(bus.out_byte),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mrst_no_resume", 32'(bus.out_valid), 32'd0);
        chk("mrst_sb_empty",  32'(sb_q.size()),   32'd0);

        // Parity pattern.
        send_word(32'h00FF0701);
        repeat (6) @(negedge clk);

        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end
endmodule
